// File: rtl/flag_condition_sequencer.sv
// Z80 condition-code evaluator and T-state sequencer for JP/JR/CALL/RET cc, DJNZ and JR e.
// Decision, T-state count and DJNZ B-1 are captured at acceptance; later input changes are ignored.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for Start; TState=0, Busy=0
// S_COUNT | counting T-states 2..n-1 after acceptance
// S_LAST  | final T-state n, Done pulse, returns to S_IDLE
module flag_condition_sequencer #(
    parameter int WIDTH_T = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [2:0]         Kind,
    input  logic [2:0]         CC,
    input  logic [7:0]         F,
    input  logic [7:0]         B,
    output logic               Busy,
    output logic               Done,
    output logic               Taken,
    output logic [WIDTH_T-1:0] TState,
    output logic               DecB,
    output logic [7:0]         BNext,
    output logic               Illegal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_LAST  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH_T-1:0] r_tstate;
    logic [WIDTH_T-1:0] r_n;
    logic               r_djnz;
    logic               r_taken;
    logic               r_illegal;
    logic [7:0]         r_bnext;

    logic               w_accept;
    logic               w_cond;
    logic               w_cond_jr;
    logic               w_taken;
    logic               w_illegal;
    logic [7:0]         w_bnext;
    logic [WIDTH_T-1:0] w_n;
    logic               w_unused;

    // Flag bits that no condition code looks at.
    assign w_unused = ^{F[5:3], F[1]};

    // Even CC values test the flag for 0, odd ones for 1.
    function automatic logic f_cond(input logic [2:0] cc, input logic [7:0] f);
        logic l_bit;
        case (cc[2:1])
            2'd0:    l_bit = f[6];
            2'd1:    l_bit = f[0];
            2'd2:    l_bit = f[2];
            default: l_bit = f[7];
        endcase
        return cc[0] ? l_bit : ~l_bit;
    endfunction

    assign w_accept  = Start && (r_state == S_IDLE);
    assign w_bnext   = B - 8'd1;
    assign w_cond    = f_cond(CC, F);
    assign w_cond_jr = f_cond({1'b0, CC[1:0]}, F);
    assign w_illegal = (Kind == 3'd6) || (Kind == 3'd7);

    always_comb begin
        w_taken = 1'b0;
        w_n     = WIDTH_T'(4);
        case (Kind)
            3'd0: begin
                w_taken = w_cond;
                w_n     = WIDTH_T'(10);
            end
            3'd1: begin
                w_taken = w_cond_jr;
                w_n     = w_cond_jr ? WIDTH_T'(12) : WIDTH_T'(7);
            end
            3'd2: begin
                w_taken = w_cond;
                w_n     = w_cond ? WIDTH_T'(17) : WIDTH_T'(10);
            end
            3'd3: begin
                w_taken = w_cond;
                w_n     = w_cond ? WIDTH_T'(11) : WIDTH_T'(5);
            end
            3'd4: begin
                w_taken = (w_bnext != 8'd0);
                w_n     = (w_bnext != 8'd0) ? WIDTH_T'(13) : WIDTH_T'(8);
            end
            3'd5: begin
                w_taken = 1'b1;
                w_n     = WIDTH_T'(12);
            end
            default: begin
                w_taken = 1'b0;
                w_n     = WIDTH_T'(4);
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_state_next = S_COUNT;
            S_COUNT: if ((r_tstate + WIDTH_T'(1)) == r_n) w_state_next = S_LAST;
            S_LAST:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy    = (r_state != S_IDLE);
        Done    = (r_state == S_LAST);
        TState  = r_tstate;
        DecB    = (r_state == S_COUNT) && (r_tstate == WIDTH_T'(2)) && r_djnz;
        Taken   = r_taken;
        Illegal = r_illegal;
        BNext   = r_bnext;
    end

    // The acceptance cycle is T1, so the counter shows T2 on the first busy cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_tstate <= '0;
        end else begin
            case (r_state)
                S_IDLE:  r_tstate <= w_accept ? WIDTH_T'(2) : '0;
                S_COUNT: r_tstate <= r_tstate + WIDTH_T'(1);
                default: r_tstate <= '0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_n       <= '0;
            r_djnz    <= 1'b0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
            r_bnext   <= 8'd0;
        end else if (w_accept) begin
            r_n       <= w_n;
            r_djnz    <= (Kind == 3'd4);
            r_taken   <= w_taken;
            r_illegal <= w_illegal;
            r_bnext   <= w_bnext;
        end
    end

endmodule

// File: tb/tb_flag_condition_sequencer.sv
// Scoreboard bench: stimulus pushes expected operations from a reference model,
// a negedge monitor compares every cycle of the DUT against the front of the queue.
module tb_flag_condition_sequencer;

    localparam int WIDTH_T = 5;

    logic               Clk;
    logic               Reset;
    logic               Start;
    logic [2:0]         Kind;
    logic [2:0]         CC;
    logic [7:0]         F;
    logic [7:0]         B;
    logic               Busy;
    logic               Done;
    logic               Taken;
    logic [WIDTH_T-1:0] TState;
    logic               DecB;
    logic [7:0]         BNext;
    logic               Illegal;

    flag_condition_sequencer #(.WIDTH_T(WIDTH_T)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Kind(Kind), .CC(CC), .F(F), .B(B),
        .Busy(Busy), .Done(Done), .Taken(Taken), .TState(TState), .DecB(DecB),
        .BNext(BNext), .Illegal(Illegal)
    );

    typedef struct {
        int c0;
        int kind;
        int n;
        bit taken;
        bit illegal;
        int bnext;
    } op_t;

    op_t q[$];
    int  cyc       = 0;
    int  free_cyc  = 0;
    int  checks    = 0;
    int  errors    = 0;
    bit  mon_en    = 0;
    int  accepts   = 0;
    bit  h_taken   = 0;
    bit  h_illegal = 0;
    int  h_bnext   = 0;

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference rules, written straight from the condition-code table.
    function automatic bit m_cond(input int cc, input logic [7:0] f);
        case (cc)
            0: return !f[6];
            1: return f[6];
            2: return !f[0];
            3: return f[0];
            4: return !f[2];
            5: return f[2];
            6: return !f[7];
            default: return f[7];
        endcase
    endfunction

    function automatic op_t m_op(input int c0, input int kind, input int cc,
                                 input logic [7:0] f, input logic [7:0] b);
        op_t o;
        int  n_tk[6] = '{10, 12, 17, 11, 13, 12};
        int  n_nt[6] = '{10, 7, 10, 5, 8, 12};
        o.c0      = c0;
        o.kind    = kind;
        o.bnext   = (int'(b) + 255) % 256;
        o.illegal = (kind >= 6);
        case (kind)
            1:       o.taken = m_cond(cc % 4, f);
            4:       o.taken = (o.bnext != 0);
            5:       o.taken = 1;
            6, 7:    o.taken = 0;
            default: o.taken = m_cond(cc, f);
        endcase
        if (kind >= 6) o.n = 4;
        else o.n = o.taken ? n_tk[kind] : n_nt[kind];
        return o;
    endfunction

    // Drives one cycle of inputs and applies the acceptance rule of the model.
    task automatic drive(input bit st, input bit rs, input int k, input int c,
                         input logic [7:0] f, input logic [7:0] b);
        @(posedge Clk);
        #1;
        Start = st;
        Reset = rs;
        Kind  = 3'(k);
        CC    = 3'(c);
        F     = f;
        B     = b;
        if (rs) begin
            free_cyc = cyc + 1;
        end else if (st && cyc >= free_cyc) begin
            op_t o;
            o = m_op(cyc, k, c, f, b);
            q.push_back(o);
            free_cyc = cyc + o.n;
            accepts++;
        end
    endtask

    task automatic issue(input int k, input int c, input logic [7:0] f, input logic [7:0] b);
        drive(1, 0, k, c, f, b);
        while (cyc + 1 < free_cyc) drive(0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    // Monitor: expected outputs per cycle derived from the front op's acceptance cycle.
    initial begin
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                bit e_busy, e_done, e_decb, fin;
                int e_ts, k;
                e_busy = 0; e_done = 0; e_decb = 0; e_ts = 0; fin = 0; k = 0;
                if (q.size() > 0) begin
                    k = cyc - q[0].c0;
                    if (k >= 1) begin
                        h_taken   = q[0].taken;
                        h_illegal = q[0].illegal;
                        h_bnext   = q[0].bnext;
                        e_busy    = (k <= q[0].n - 1);
                        e_ts      = e_busy ? k + 1 : 0;
                        e_done    = (k == q[0].n - 1);
                        e_decb    = (k == 1) && (q[0].kind == 4);
                        fin       = e_done;
                    end
                end
                chk("busy",    32'(Busy),    32'(e_busy));
                chk("done",    32'(Done),    32'(e_done));
                chk("tstate",  32'(TState),  32'(e_ts));
                chk("decb",    32'(DecB),    32'(e_decb));
                chk("taken",   32'(Taken),   32'(h_taken));
                chk("illegal", 32'(Illegal), 32'(h_illegal));
                chk("bnext",   32'(BNext),   32'(h_bnext));
                if (fin) void'(q.pop_front());
                if (Reset === 1'b1) begin
                    q.delete();
                    h_taken   = 0;
                    h_illegal = 0;
                    h_bnext   = 0;
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        Start = 0; Reset = 1; Kind = 0; CC = 0; F = 0; B = 0;
        drive(0, 1, 0, 0, 8'h00, 8'h00);
        drive(0, 1, 0, 0, 8'h00, 8'h00);
        mon_en = 1;
        drive(0, 0, 0, 0, 8'h00, 8'h00);

        // JR NZ not taken / taken
        issue(1, 0, 8'h40, 8'h00);
        issue(1, 0, 8'h00, 8'h00);
        // JR cc ignores CC[2]: CC=5 behaves as Z
        issue(1, 5, 8'h40, 8'h00);
        // DJNZ boundaries
        issue(4, 0, 8'h00, 8'h01);
        issue(4, 0, 8'h00, 8'h00);
        // CALL PE, RET M, JP C
        issue(2, 5, 8'h04, 8'h00);
        issue(3, 7, 8'h00, 8'h00);
        issue(0, 3, 8'h01, 8'h00);
        drive(0, 0, 0, 0, 8'h00, 8'h00);

        // CALL with F toggled, Start while busy, then reset mid-operation
        drive(1, 0, 2, 5, 8'h04, 8'h00);
        drive(0, 0, 2, 5, 8'h04, 8'h00);
        drive(0, 0, 2, 5, 8'h00, 8'h00);
        drive(0, 0, 2, 5, 8'h00, 8'h00);
        drive(0, 0, 2, 5, 8'h00, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        drive(0, 1, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        issue(3, 6, 8'h00, 8'h10);

        // Reserved kind followed by JR e
        issue(7, 0, 8'hFF, 8'h00);
        issue(5, 0, 8'h00, 8'h00);

        // Start held high: re-acceptance on the cycle after each Done
        for (int i = 0; i < 40; i++) drive(1, 0, 5, 0, 8'h00, 8'h00);
        for (int i = 0; i < 30; i++) drive(1, 0, 1, 1, 8'h00, 8'h05);
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        while (cyc + 1 < free_cyc) drive(0, 0, 0, 0, 8'h00, 8'h00);

        // Random traffic with occasional reset
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] rb;
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(0, 2));
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  8'($urandom), rb);
        end

        // Drain with a bounded wait
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 40) begin
            drive(0, 0, 0, 0, 8'h00, 8'h00);
            wait_cnt++;
        end
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        chk("drain", 32'(q.size()), 32'd0);
        chk("accepts_seen", 32'(accepts > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
